// File: rtl/stitch_nest_sequencer.sv
// Two-level FPU repetition sequencer: ring buffer replayed under queued loop configs.
// Define STITCH_SEQ_STAGGER_EN to include register-field staggering.
module stitch_nest_sequencer #(
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned Depth       = 16,
    parameter int unsigned CfgDepth    = 4,
    parameter int unsigned RptBits     = 16,
    parameter int unsigned StaggerBits = 3,
    localparam int unsigned DepthBits  = $clog2(Depth)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [DepthBits-1:0]   cfg_max_inst_i,
    input  logic [RptBits-1:0]     cfg_max_inner_i,
    input  logic [RptBits-1:0]     cfg_max_outer_i,
    input  logic [StaggerBits-1:0] cfg_stagger_max_i,
    input  logic [3:0]             cfg_stagger_mask_i,
    input  logic                   inst_valid_i,
    output logic                   inst_ready_o,
    input  logic [31:0]            inst_op_i,
    input  logic [AddrWidth-1:0]   inst_argc_i,
    output logic                   oup_valid_o,
    input  logic                   oup_ready_i,
    output logic [31:0]            oup_op_o,
    output logic [AddrWidth-1:0]   oup_argc_o,
    output logic                   oup_last_o,
    output logic                   busy_o
);

    localparam int unsigned CfgAw = (CfgDepth > 1) ? $clog2(CfgDepth) : 1;
    localparam int unsigned CfgCw = $clog2(CfgDepth + 1);

    typedef logic [DepthBits:0] ptr_t;

    logic [31:0]          mem_op   [Depth];
    logic [AddrWidth-1:0] mem_argc [Depth];

    logic [DepthBits-1:0] cf_inst  [CfgDepth];
    logic [RptBits-1:0]   cf_inner [CfgDepth];
    logic [RptBits-1:0]   cf_outer [CfgDepth];
    ptr_t                 cf_tag   [CfgDepth];

    ptr_t                 wr_q, base_q, fill;
    logic [CfgAw-1:0]     cf_wp_q, cf_rp_q;
    logic [CfgCw-1:0]     cf_cnt_q;
    logic [RptBits-1:0]   rpt_q, outer_q, max_inner, max_outer;
    logic [DepthBits-1:0] inst_q, max_inst, rd_idx;
    logic [31:0]          raw_op, op_stg;
    logic                 full, cfg_full, active, last;
    logic                 fire, inst_fire, cfg_fire, pop;

    assign fill      = wr_q - base_q;
    assign full      = (fill == ptr_t'(Depth));
    assign cfg_full  = (cf_cnt_q == CfgCw'(CfgDepth));
    assign active    = (cf_cnt_q != '0) && (cf_tag[cf_rp_q] == base_q);

    assign max_inst  = active ? cf_inst[cf_rp_q]  : '0;
    assign max_inner = active ? cf_inner[cf_rp_q] : '0;
    assign max_outer = active ? cf_outer[cf_rp_q] : '0;

    assign last      = (rpt_q == max_inner) && (inst_q == max_inst)
                    && (outer_q == max_outer);
    assign rd_idx    = base_q[DepthBits-1:0] + inst_q;
    assign raw_op    = mem_op[rd_idx];

    assign inst_ready_o = ~full & ~flush_i;
    assign cfg_ready_o  = ~cfg_full & ~flush_i;
    assign oup_valid_o  = ({1'b0, inst_q} < fill) & ~flush_i;

    assign fire      = oup_valid_o & oup_ready_i;
    assign inst_fire = inst_valid_i & inst_ready_o;
    assign cfg_fire  = cfg_valid_i & cfg_ready_o;
    assign pop       = fire & last & active;

    assign oup_op_o   = oup_valid_o ? op_stg : '0;
    assign oup_argc_o = oup_valid_o ? mem_argc[rd_idx] : '0;
    assign oup_last_o = oup_valid_o & last;
    assign busy_o     = (fill != '0) | (cf_cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (inst_fire) begin
            mem_op[wr_q[DepthBits-1:0]]   <= inst_op_i;
            mem_argc[wr_q[DepthBits-1:0]] <= inst_argc_i;
        end
        if (cfg_fire) begin
            cf_inst[cf_wp_q]  <= cfg_max_inst_i;
            cf_inner[cf_wp_q] <= cfg_max_inner_i;
            cf_outer[cf_wp_q] <= cfg_max_outer_i;
            cf_tag[cf_wp_q]   <= wr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q     <= '0;
            base_q   <= '0;
            cf_wp_q  <= '0;
            cf_rp_q  <= '0;
            cf_cnt_q <= '0;
        end else if (flush_i) begin
            wr_q     <= '0;
            base_q   <= '0;
            cf_wp_q  <= '0;
            cf_rp_q  <= '0;
            cf_cnt_q <= '0;
        end else begin
            if (inst_fire) wr_q <= wr_q + 1'b1;
            if (fire && last) base_q <= base_q + ptr_t'(max_inst) + 1'b1;
            if (cfg_fire)
                cf_wp_q <= (cf_wp_q == CfgAw'(CfgDepth - 1)) ? '0 : cf_wp_q + 1'b1;
            if (pop)
                cf_rp_q <= (cf_rp_q == CfgAw'(CfgDepth - 1)) ? '0 : cf_rp_q + 1'b1;
            unique case ({cfg_fire, pop})
                2'b10:   cf_cnt_q <= cf_cnt_q + 1'b1;
                2'b01:   cf_cnt_q <= cf_cnt_q - 1'b1;
                default: cf_cnt_q <= cf_cnt_q;
            endcase
        end
    end

    // Innermost repeat first, then body index, then outer pass.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rpt_q   <= '0;
            inst_q  <= '0;
            outer_q <= '0;
        end else if (flush_i || (fire && last)) begin
            rpt_q   <= '0;
            inst_q  <= '0;
            outer_q <= '0;
        end else if (fire) begin
            if (rpt_q != max_inner) begin
                rpt_q <= rpt_q + 1'b1;
            end else begin
                rpt_q <= '0;
                if (inst_q != max_inst) begin
                    inst_q <= inst_q + 1'b1;
                end else begin
                    inst_q  <= '0;
                    outer_q <= outer_q + 1'b1;
                end
            end
        end
    end

`ifdef STITCH_SEQ_STAGGER_EN
    logic [StaggerBits-1:0] cf_smax  [CfgDepth];
    logic [3:0]             cf_smask [CfgDepth];
    logic [StaggerBits-1:0] stg_q, stg_max;
    logic [3:0]             stg_mask;
    logic [4:0]             stg_add;

    assign stg_max  = active ? cf_smax[cf_rp_q]  : '0;
    assign stg_mask = active ? cf_smask[cf_rp_q] : '0;
    assign stg_add  = 5'(stg_q);

    always_ff @(posedge clk_i) begin
        if (cfg_fire) begin
            cf_smax[cf_wp_q]  <= cfg_stagger_max_i;
            cf_smask[cf_wp_q] <= cfg_stagger_mask_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stg_q <= '0;
        end else if (flush_i || (fire && last)) begin
            stg_q <= '0;
        end else if (fire) begin
            stg_q <= (stg_q == stg_max) ? '0 : stg_q + 1'b1;
        end
    end

    always_comb begin
        op_stg = raw_op;
        if (stg_mask[0]) op_stg[11:7]  = raw_op[11:7]  + stg_add;
        if (stg_mask[1]) op_stg[19:15] = raw_op[19:15] + stg_add;
        if (stg_mask[2]) op_stg[24:20] = raw_op[24:20] + stg_add;
        if (stg_mask[3]) op_stg[31:27] = raw_op[31:27] + stg_add;
    end
`else
    logic unused_stg;
    assign unused_stg = ^{cfg_stagger_max_i, cfg_stagger_mask_i};
    assign op_stg     = raw_op;
`endif

    illegal_max_inst: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        cfg_fire |-> (32'(cfg_max_inst_i) < 32'(Depth)));

endmodule

// File: tb/tb_stitch_nest_sequencer.sv
// Scoreboard bench for stitch_nest_sequencer (Depth = 4).
module tb_stitch_nest_sequencer;

    typedef logic [64:0] ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_inst = '0;
    logic [15:0] cfg_inner = '0;
    logic [15:0] cfg_outer = '0;
    logic [2:0]  cfg_smax = '0;
    logic [3:0]  cfg_smask = '0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [31:0] inst_op = '0;
    logic [31:0] inst_argc = '0;
    logic        oup_valid;
    logic        oup_ready = 1'b0;
    logic [31:0] oup_op;
    logic [31:0] oup_argc;
    logic        oup_last;
    logic        busy;

    ent_t exp_q[$];
    ent_t got_q[$];
    int checks = 0;
    int failures = 0;

    stitch_nest_sequencer #(.Depth(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_max_inst_i(cfg_inst), .cfg_max_inner_i(cfg_inner),
        .cfg_max_outer_i(cfg_outer), .cfg_stagger_max_i(cfg_smax),
        .cfg_stagger_mask_i(cfg_smask),
        .inst_valid_i(inst_valid), .inst_ready_o(inst_ready),
        .inst_op_i(inst_op), .inst_argc_i(inst_argc),
        .oup_valid_o(oup_valid), .oup_ready_i(oup_ready),
        .oup_op_o(oup_op), .oup_argc_o(oup_argc),
        .oup_last_o(oup_last), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n && oup_valid && oup_ready)
            got_q.push_back({oup_last, oup_argc, oup_op});

    function automatic logic [31:0] stg_exp(logic [31:0] op, logic [3:0] m, int k);
        logic [31:0] r;
        logic en;
`ifdef STITCH_SEQ_STAGGER_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        r = op;
        if (en && m[0]) r[11:7]  = op[11:7]  + 5'(k);
        if (en && m[1]) r[19:15] = op[19:15] + 5'(k);
        if (en && m[2]) r[24:20] = op[24:20] + 5'(k);
        if (en && m[3]) r[31:27] = op[31:27] + 5'(k);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cfg(input logic [1:0] mi, input logic [15:0] mn,
                            input logic [15:0] mo, input logic [2:0] sm,
                            input logic [3:0] sk);
        int n;
        cfg_inst = mi; cfg_inner = mn; cfg_outer = mo;
        cfg_smax = sm; cfg_smask = sk;
        cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 100) begin tick(); n++; end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL cfg_push_timeout actual=%0d cycles required=<100", n);
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic push_op(input logic [31:0] op, input logic [31:0] argc);
        int n;
        inst_op = op; inst_argc = argc;
        inst_valid = 1'b1;
        n = 0;
        while (!inst_ready && n < 100) begin tick(); n++; end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL inst_push_timeout actual=%0d cycles required=<100", n);
        end
        tick();
        inst_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        while (busy && n < 300) begin tick(); n++; end
        ok = (n < 300);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (oup_valid !== 1'b0) begin failures++;
            $display("FAIL rst_valid_async actual=%b required=0", oup_valid); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (oup_valid !== 1'b0) begin failures++;
            $display("FAIL rst_valid actual=%b required=0", oup_valid); end
        checks++;
        if (oup_op !== 32'h0) begin failures++;
            $display("FAIL rst_op actual=%h required=0", oup_op); end
        checks++;
        if (oup_argc !== 32'h0) begin failures++;
            $display("FAIL rst_argc actual=%h required=0", oup_argc); end
        checks++;
        if (oup_last !== 1'b0) begin failures++;
            $display("FAIL rst_last actual=%b required=0", oup_last); end
        checks++;
        if (busy !== 1'b0) begin failures++;
            $display("FAIL rst_busy actual=%b required=0", busy); end
        checks++;
        if (cfg_ready !== 1'b1) begin failures++;
            $display("FAIL rst_cfg_ready actual=%b required=1", cfg_ready); end
        checks++;
        if (inst_ready !== 1'b1) begin failures++;
            $display("FAIL rst_inst_ready actual=%b required=1", inst_ready); end
    endtask

    task automatic test_bypass();
        ent_t g, e;
        logic [31:0] op;
        oup_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            op = 32'h1000_0053 + 32'(k) * 32'h0101_1000;
            exp_q.push_back({1'b1, 32'(100 + k), op});
            push_op(op, 32'(100 + k));
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++;
            $display("FAIL bypass_busy actual=%b required=0", busy); end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++;
            $display("FAIL bypass_count actual=%0d required=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin failures++;
                $display("FAIL bypass_data actual=%h required=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_nested();
        ent_t g, e;
        bit ok;
        logic [31:0] ops [2];
        int n;
        ops[0] = 32'hAAAA_0043;
        ops[1] = 32'hBBBB_0047;
        oup_ready = 1'b1;
        n = 0;
        for (int o = 0; o < 2; o++)
            for (int i = 0; i < 2; i++)
                for (int r = 0; r < 2; r++) begin
                    n++;
                    exp_q.push_back({n == 8, 32'(200 + i), ops[i]});
                end
        push_cfg(2'd1, 16'd1, 16'd1, 3'd0, 4'd0);
        push_op(ops[0], 32'd200);
        push_op(ops[1], 32'd201);
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++;
            $display("FAIL nested_timeout actual=busy required=idle"); end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++;
            $display("FAIL nested_count actual=%0d required=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin failures++;
                $display("FAIL nested_data actual=%h required=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_stagger();
        ent_t g, e;
        bit ok;
        logic [31:0] op;
        op = {5'd30, 2'b00, 5'd2, 5'd1, 3'b000, 5'd31, 7'h43};
        oup_ready = 1'b1;
        for (int r = 0; r < 4; r++)
            exp_q.push_back({r == 3, 32'd300, stg_exp(op, 4'b0001, r % 2)});
        push_cfg(2'd0, 16'd3, 16'd0, 3'd1, 4'b0001);
        push_op(op, 32'd300);
        for (int r = 0; r < 3; r++)
            exp_q.push_back({r == 2, 32'd301, stg_exp(op, 4'b1110, r)});
        push_cfg(2'd0, 16'd2, 16'd0, 3'd2, 4'b1110);
        push_op(op, 32'd301);
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++;
            $display("FAIL stagger_timeout actual=busy required=idle"); end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++;
            $display("FAIL stagger_count actual=%0d required=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin failures++;
                $display("FAIL stagger_data actual=%h required=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_full_backpressure();
        ent_t g, e;
        bit ok, acc, stalled;
        int hs, n;
        logic [31:0] prev_op, prev_argc;
        logic [31:0] op5;
        op5 = 32'h5555_00d3;
        oup_ready = 1'b0;
        n = 0;
        for (int o = 0; o < 3; o++)
            for (int i = 0; i < 4; i++) begin
                n++;
                exp_q.push_back({n == 12, 32'(400 + i), 32'hC000_0053 + 32'(i << 12)});
            end
        exp_q.push_back({1'b1, 32'd499, op5});
        push_cfg(2'd3, 16'd0, 16'd2, 3'd0, 4'd0);
        for (int i = 0; i < 4; i++)
            push_op(32'hC000_0053 + 32'(i << 12), 32'(400 + i));
        inst_op = op5; inst_argc = 32'd499; inst_valid = 1'b1;
        hs = 0; acc = 1'b0; stalled = 1'b0;
        prev_op = '0; prev_argc = '0;
        for (int c = 0; c < 100 && !acc; c++) begin
            oup_ready = c[0];
            checks++;
            if (inst_ready !== (hs == 12)) begin failures++;
                $display("FAIL full_ready actual=%b required=%b hs=%0d", inst_ready, hs == 12, hs); end
            if (stalled) begin
                checks++;
                if (oup_op !== prev_op || oup_argc !== prev_argc) begin failures++;
                    $display("FAIL full_stable actual=%h required=%h", oup_op, prev_op); end
            end
            stalled = oup_valid && !oup_ready;
            prev_op = oup_op; prev_argc = oup_argc;
            if (oup_valid && oup_ready) hs++;
            if (inst_ready) acc = 1'b1;
            tick();
        end
        inst_valid = 1'b0;
        checks++;
        if (!acc) begin failures++;
            $display("FAIL full_accept actual=0 required=1"); end
        checks++;
        if (oup_valid !== 1'b1 || oup_op !== op5) begin failures++;
            $display("FAIL full_next actual=%b/%h required=1/%h", oup_valid, oup_op, op5); end
        oup_ready = 1'b1;
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++;
            $display("FAIL full_timeout actual=busy required=idle"); end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++;
            $display("FAIL full_count actual=%0d required=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin failures++;
                $display("FAIL full_data actual=%h required=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_late_body();
        ent_t g, e;
        logic [31:0] op;
        oup_ready = 1'b1;
        push_cfg(2'd2, 16'd0, 16'd0, 3'd0, 4'd0);
        checks++;
        if (oup_valid !== 1'b0) begin failures++;
            $display("FAIL late_empty actual=%b required=0", oup_valid); end
        for (int k = 0; k < 3; k++) begin
            op = 32'hD000_0043 + 32'(k << 7);
            exp_q.push_back({k == 2, 32'(500 + k), op});
            push_op(op, 32'(500 + k));
            checks++;
            if (oup_valid !== 1'b1) begin failures++;
                $display("FAIL late_valid actual=%b required=1 k=%0d", oup_valid, k); end
            tick();
            checks++;
            if (oup_valid !== 1'b0) begin failures++;
                $display("FAIL late_wait actual=%b required=0 k=%0d", oup_valid, k); end
            tick();
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++;
            $display("FAIL late_count actual=%0d required=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin failures++;
                $display("FAIL late_data actual=%h required=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_flush();
        ent_t g, e;
        bit ok;
        logic [31:0] xy [2];
        xy[0] = 32'h0F0F_0053;
        xy[1] = 32'hF0F0_0053;
        oup_ready = 1'b0;
        push_cfg(2'd3, 16'd3, 16'd0, 3'd0, 4'd0);
        for (int i = 0; i < 4; i++)
            push_op(32'hE000_0053 + 32'(i << 20), 32'(600 + i));
        exp_q.push_back({1'b0, 32'd600, 32'hE000_0053});
        exp_q.push_back({1'b0, 32'd600, 32'hE000_0053});
        oup_ready = 1'b1;
        tick(); tick();
        checks++;
        if (oup_valid !== 1'b1) begin failures++;
            $display("FAIL flush_pre_valid actual=%b required=1", oup_valid); end
        flush = 1'b1;
        #1;
        checks++;
        if (oup_valid !== 1'b0 || cfg_ready !== 1'b0 || inst_ready !== 1'b0) begin failures++;
            $display("FAIL flush_gate actual=%b%b%b required=000", oup_valid, cfg_ready, inst_ready); end
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (oup_valid !== 1'b0) begin failures++;
            $display("FAIL flush_valid actual=%b required=0", oup_valid); end
        checks++;
        if (busy !== 1'b0) begin failures++;
            $display("FAIL flush_busy actual=%b required=0", busy); end
        for (int o = 0; o < 2; o++)
            for (int i = 0; i < 2; i++)
                exp_q.push_back({o == 1 && i == 1, 32'(700 + i), xy[i]});
        push_cfg(2'd1, 16'd0, 16'd1, 3'd0, 4'd0);
        push_op(xy[0], 32'd700);
        push_op(xy[1], 32'd701);
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++;
            $display("FAIL flush_timeout actual=busy required=idle"); end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++;
            $display("FAIL flush_count actual=%0d required=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin failures++;
                $display("FAIL flush_data actual=%h required=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        ent_t g, e;
        oup_ready = 1'b1;
        push_cfg(2'd0, 16'd0, 16'd3, 3'd0, 4'd0);
        exp_q.push_back({1'b0, 32'd800, 32'h8888_0053});
        exp_q.push_back({1'b0, 32'd800, 32'h8888_0053});
        push_op(32'h8888_0053, 32'd800);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (oup_valid !== 1'b0 || busy !== 1'b0) begin failures++;
            $display("FAIL rstmid_idle actual=%b%b required=00", oup_valid, busy); end
        tick();
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (oup_valid !== 1'b0) begin failures++;
            $display("FAIL rstmid_after actual=%b required=0", oup_valid); end
        checks++;
        if (got_q.size() != exp_q.size()) begin failures++;
            $display("FAIL rstmid_count actual=%0d required=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin failures++;
                $display("FAIL rstmid_data actual=%h required=%h", g, e); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_nested();
        test_stagger();
        test_full_backpressure();
        test_late_body();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stitch_nest_sequencer.md
# stitch_nest_sequencer

Parametrised next-generation FPU repetition sequencer for the Stitch FPU subsystem. Sits between the integer core's offload port and the FPU issue stage. It buffers loop-body instructions in a ring buffer and replays them under a queued loop configuration: an outer body loop, an inner per-instruction repeat, and optional register staggering. Compared with the single-level repetition sequencer, it adds two-level nesting, parametrised counter and stagger widths, a last-emission flag and a synchronous flush.

## Interface
Parameters:
- `AddrWidth`, 32: width of the `argc` payload.
- `Depth`, 16: ring-buffer entries; power of two, 2..1024. `DepthBits = $clog2(Depth)` is derived.
- `CfgDepth`, 4: number of configuration FIFO entries.
- `RptBits`, 16: width of the inner and outer repeat counters.
- `StaggerBits`, 3: width of the stagger counter; must be 5 or less.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  synchronous abort and clear.
- `cfg_valid_i` / `cfg_ready_o`  in/out  1  configuration handshake.
- `cfg_max_inst_i`  in  DepthBits  body length minus 1.
- `cfg_max_inner_i`  in  RptBits  inner repeat count minus 1.
- `cfg_max_outer_i`  in  RptBits  outer repeat count minus 1.
- `cfg_stagger_max_i`  in  StaggerBits  stagger wrap value.
- `cfg_stagger_mask_i`  in  4  stagger enables: bit 0 = rd [11:7], bit 1 = rs1 [19:15], bit 2 = rs2 [24:20], bit 3 = rs3 [31:27].
- `inst_valid_i` / `inst_ready_o`  in/out  1  instruction handshake.
- `inst_op_i`  in  32  RISC-V instruction word.
- `inst_argc_i`  in  AddrWidth  instruction payload.
- `oup_valid_o` / `oup_ready_i`  out/in  1  issue handshake.
- `oup_op_o`  out  32  issued instruction word.
- `oup_argc_o`  out  AddrWidth  issued payload.
- `oup_last_o`  out  1  marks the final emission of a sequence.
- `busy_o`  out  1  high while the ring buffer is non-empty or a configuration is queued.

## Operation
- **Ring buffer.** `Depth` entries of {op, argc}. Write pointer `wr` and base pointer `base` are `DepthBits+1` wide and wrap naturally.
  - Fill level = `wr - base`.
  - Full when the fill level equals `Depth`; `inst_ready_o = ~full & ~flush_i`.
- **Configuration FIFO.** `CfgDepth` entries. Each entry is tagged with `wr` at the moment it is pushed. `cfg_ready_o = ~cfg_full & ~flush_i`.
- **Ordering rule.** A configuration must be pushed before the first instruction of its body.
- **Active configuration.** The FIFO head is active when the FIFO is non-empty and its tag equals `base`. Otherwise the entry at `base` is issued once, with all maxima treated as 0 and stagger disabled.
- **Emission order.**
  - Nesting, outermost first: `o` from 0 to `max_outer`, then `i` from 0 to `max_inst`, then `r` from 0 to `max_inner`.
  - Each step emits entry `base + i`.
  - Counters: `rpt_cnt` (r), `inst_cnt` (i), `outer_cnt` (o). All advance only on an `oup_valid_o & oup_ready_i` handshake.
- **Output valid.** `oup_valid_o = (inst_cnt < fill level) & ~flush_i`, so the output waits for body entries that have not yet arrived.
- **End of sequence.** The last emission is `r == max_inner`, `i == max_inst` and `o == max_outer`; `oup_last_o` is high on it.
  - On its handshake: `base += max_inst + 1`, the configuration is popped (if one was active), and all counters clear.
- **Stagger.**
  - `stg_cnt` advances on every handshake and wraps to 0 after `stagger_max`. It clears at end of sequence.
  - Each masked 5-bit register field has `stg_cnt` added to it, modulo 32.
- **Flush.** While `flush_i` is high, all readies and valids are 0. On the clock edge it clears `wr`, `base`, all counters and the configuration FIFO.
- **Data masking.** When `oup_valid_o` is 0, `oup_op_o`, `oup_argc_o` and `oup_last_o` are driven to 0.
- **Illegal configuration.** `max_inst >= Depth` is illegal and is flagged by a simulation assertion.

## Timing
- **Reset values.** `oup_valid_o` = 0, `oup_op_o` = 0, `oup_argc_o` = 0, `oup_last_o` = 0, `busy_o` = 0, `cfg_ready_o` = 1, `inst_ready_o` = 1.
- **Latency.**
  - An instruction accepted in cycle t can be issued in cycle t+1 at the earliest.
  - A configuration accepted in cycle t governs issue from cycle t+1.
- **Throughput.** One emission per cycle while `oup_ready_i` is high.
- **Output stability.** Outputs are combinational from registered state only; there is no path from `oup_ready_i` to `oup_valid_o`. The output holds stable while valid is high and ready is low.
- **Simultaneous push and retire.**
  - A push and an end-of-sequence retire may occur in the same cycle, including when the buffer is full: the freed slots are visible in the next cycle.
  - A configuration push and pop in the same cycle on a full FIFO is refused (`cfg_ready_o` is registered-full based).
- **Reset mid-sequence.** Abandons the sequence without emitting anything further.

## Configuration
- `STITCH_SEQ_STAGGER_EN`
  - Defined: the stagger counter and the field adders are present, as described above.
  - Undefined: the stagger logic is removed; `cfg_stagger_*` inputs are ignored and `oup_op_o` equals the stored op unchanged.

## Test plan
- **Plain bypass.** No configuration; push 3 ops A, B, C with `oup_ready_i` = 1 → A, B, C each issued once in consecutive cycles. `oup_last_o` = 1 on each; `busy_o` falls after C.
- **Nested loop.** Configuration `max_inst` = 1, `max_inner` = 1, `max_outer` = 1; push ops A, B → A A B B A A B B. `oup_last_o` is high only on the 8th emission.
- **Stagger** (macro defined). Configuration `max_inner` = 3, `stagger_max` = 1, mask = 0001; op with rd = 31 → rd sequence 31, 0, 31, 0 (wraps modulo 32).
- **Full and backpressure.** Depth = 4, `max_inst` = 3, `max_outer` = 2; push 4 ops, then a 5th, with `oup_ready_i` toggling every cycle.
  - `inst_ready_o` stays 0 until the 12th handshake.
  - The 5th op is then accepted and issues next.
  - Output data is stable during stalls.
- **Late body.** Push the configuration with `max_inst` = 2, then ops spaced 3 cycles apart → `oup_valid_o` stays low until each entry is written, and the order is preserved.
- **Flush mid-sequence.** Assert `flush_i` for 1 cycle during the 3rd emission of a 16-emission loop.
  - The next cycle shows `oup_valid_o` = 0 and `busy_o` = 0.
  - A fresh configuration afterwards runs correctly from pointer 0.
